alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
//   16-bit ALU for the RISC-16 processor datapath. Takes two register
//   operands and a 4-bit opcode, and computes arithmetic, logic, shift or
//   move results. Result and flags (carry, zero, parity) are registered
//   with one-cycle latency. Output feeds register-file write-back and the
//   flag logic.
//
// PARAMETERS
//   none (datapath width fixed at 16, opcode width fixed at 4)
//
// PORTS
//   clk       input   1   system clock; all state updates on rising edge
//   rst       input   1   synchronous, active-high reset
//   Rx_value  input  16   operand A (first source register)
//   Ry_value  input  16   operand B (second source register / shift amount)
//   opcode    input   4   operation select
//   alu_out   output 16   registered result
//   carry     output  1   registered carry/borrow/overflow flag
//   zero      output  1   registered: result == 0
//   parity    output  1   registered even-parity flag of result
//
// BEHAVIOUR
//   - One clock, synchronous active-high reset. No enable: inputs are
//     sampled on every rising clk edge.
//   - Outputs are valid one cycle after the inputs are sampled.
//   - rst=1 at an edge: alu_out=0, carry=0, zero=0, parity=0.
//     Reset overrides any operation in flight.
//   - Opcode map (A=Rx_value, B=Ry_value, R=result, all unsigned mod 2^16):
//     0 NOP: R=0, carry=0
//     1 ADD: R=A+B; carry = bit 16 of the 17-bit sum
//     2 SUB: R=A-B; carry = borrow (1 iff A<B)
//     3 MUL: R = low 16 bits of A*B; carry = 1 iff high 16 bits != 0
//     4 AND: R=A&B     5 OR: R=A|B     6 XOR: R=A^B
//     7 NOT: R=~A      (logic ops 4-7: carry=0)
//     8 SHL: R=A<<B[3:0]; carry = last bit shifted out
//     9 SHR: R=A>>B[3:0] (logical); carry = last bit shifted out
//     A ASR: arithmetic right shift of A by B[3:0], sign-filled;
//            carry = last bit shifted out
//     B ROL / C ROR: rotate A by B[3:0]; carry = final R[0] / R[15]
//     D INC: R=A+1; carry on wrap from FFFF
//     E DEC: R=A-1; carry (borrow) on wrap from 0000
//     F MOV: R=B, carry=0
//   - Shift/rotate amount 0: R=A, carry=0. B[15:4] ignored for opcodes 8-C.
//   - zero = (R==16'h0000), for every opcode including NOP.
//   - parity = ~^R: 1 when R has an even number of 1 bits (R=0 -> parity=1).
//   - No other state; back-to-back opcodes are independent each cycle.
//
// TESTING
//   - Reset: rst=1 for 2 edges -> alu_out=0000, carry=0, zero=0, parity=0.
//   - ADD A=0005 B=0003 -> next cycle alu_out=0008, carry=0, zero=0,
//     parity=0. ADD FFFF+0001 -> 0000, carry=1, zero=1, parity=1.
//   - MUL A=0005 B=0003 -> alu_out=000F, parity=1, carry=0.
//     MUL 0100*0100 -> 0000, carry=1, zero=1.
//   - SUB 0005-0003 -> 0002, carry=0, parity=0.
//     SUB 0005-0005 -> 0000, zero=1.
//     SUB 0003-0005 -> FFFE, carry=1.
//   - SHL 8001 by 1 -> 0002, carry=1.
//     ASR 8000 by 4 -> F800, carry=0.
//     ROR 0001 by 1 -> 8000, carry=1.
//   - Assert rst mid-stream with opcode=ADD active -> outputs clear the
//     same edge. Deassert -> next edge shows the ADD result.

Source files
------------

// File: rtl/alu.sv
// 16-bit registered ALU for the RISC-16 datapath.
// Result and carry/zero/parity flags appear one cycle after operand capture.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Rx_value,
  input  logic [15:0] Ry_value,
  input  logic [3:0]  opcode,
  output logic [15:0] alu_out,
  output logic        carry,
  output logic        zero,
  output logic        parity
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_MUL = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_ASR = 4'hA,
    OP_ROL = 4'hB,
    OP_ROR = 4'hC,
    OP_INC = 4'hD,
    OP_DEC = 4'hE,
    OP_MOV = 4'hF
  } op_e;

  logic [3:0]  amt;
  logic [16:0] sum;
  logic [16:0] diff;
  logic [16:0] inc;
  logic [16:0] dec;
  logic [31:0] prod;
  logic [16:0] shl;
  logic [16:0] shr;
  logic [16:0] asr;
  logic [31:0] rol2;
  logic [31:0] ror2;
  logic [15:0] res;
  logic        cy;

  assign amt  = Ry_value[3:0];
  assign sum  = {1'b0, Rx_value} + {1'b0, Ry_value};
  assign diff = {1'b0, Rx_value} - {1'b0, Ry_value};
  assign inc  = {1'b0, Rx_value} + 17'd1;
  assign dec  = {1'b0, Rx_value} - 17'd1;
  assign prod = Rx_value * Ry_value;

  // A spare bit beside the operand catches the last bit shifted out;
  // an amount of 0 leaves that spare bit at 0, so carry clears.
  assign shl = {1'b0, Rx_value} << amt;
  assign shr = {Rx_value, 1'b0} >> amt;
  assign asr = $unsigned($signed({Rx_value, 1'b0}) >>> amt);

  // Doubling the word turns a rotate into a plain shift.
  assign rol2 = {Rx_value, Rx_value} << amt;
  assign ror2 = {Rx_value, Rx_value} >> amt;

  always_comb begin
    res = 16'h0000;
    cy  = 1'b0;
    unique case (op_e'(opcode))
      OP_NOP: begin
        res = 16'h0000;
      end
      OP_ADD: begin
        res = sum[15:0];
        cy  = sum[16];
      end
      OP_SUB: begin
        res = diff[15:0];
        cy  = diff[16];
      end
      OP_MUL: begin
        res = prod[15:0];
        cy  = |prod[31:16];
      end
      OP_AND: res = Rx_value & Ry_value;
      OP_OR:  res = Rx_value | Ry_value;
      OP_XOR: res = Rx_value ^ Ry_value;
      OP_NOT: res = ~Rx_value;
      OP_SHL: begin
        res = shl[15:0];
        cy  = shl[16];
      end
      OP_SHR: begin
        res = shr[16:1];
        cy  = shr[0];
      end
      OP_ASR: begin
        res = asr[16:1];
        cy  = asr[0];
      end
      OP_ROL: begin
        res = rol2[31:16];
        cy  = (amt != 4'd0) && rol2[16];
      end
      OP_ROR: begin
        res = ror2[15:0];
        cy  = (amt != 4'd0) && ror2[15];
      end
      OP_INC: begin
        res = inc[15:0];
        cy  = inc[16];
      end
      OP_DEC: begin
        res = dec[15:0];
        cy  = dec[16];
      end
      OP_MOV: begin
        res = Ry_value;
      end
      default: begin
        res = 16'h0000;
        cy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= 16'h0000;
      carry   <= 1'b0;
      zero    <= 1'b0;
      parity  <= 1'b0;
    end else begin
      alu_out <= res;
      carry   <= cy;
      zero    <= (res == 16'h0000);
      parity  <= ~^res;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered 16-bit ALU.
// Each task drives its own vectors and checks hand-computed results.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] Rx_value;
  logic [15:0] Ry_value;
  logic [3:0]  opcode;
  logic [15:0] alu_out;
  logic        carry;
  logic        zero;
  logic        parity;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        p;
  } vec_t;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .Rx_value (Rx_value),
    .Ry_value (Ry_value),
    .opcode   (opcode),
    .alu_out  (alu_out),
    .carry    (carry),
    .zero     (zero),
    .parity   (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [3:0] op,
                      input logic [15:0] a,
                      input logic [15:0] b);
    @(negedge clk);
    opcode   = op;
    Rx_value = a;
    Ry_value = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    opcode   = 4'h1;
    Rx_value = 16'h1234;
    Ry_value = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({alu_out, carry, zero, parity} !== {16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL reset: got out=%h c=%b z=%b p=%b want 0000 0 0 0",
               alu_out, carry, zero, parity);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v[10];
    v = '{
      '{4'h1, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0},
      '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1},
      '{4'h3, 16'h0005, 16'h0003, 16'h000F, 1'b0, 1'b0, 1'b1},
      '{4'h3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b1},
      '{4'h2, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0},
      '{4'h2, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1},
      '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0},
      '{4'hD, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1},
      '{4'hE, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1},
      '{4'hD, 16'h0007, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({alu_out, carry, zero, parity} !==
          {v[i].r, v[i].c, v[i].z, v[i].p}) begin
        failures++;
        $display("FAIL arith[%0d] op=%h: got %h c%b z%b p%b want %h c%b z%b p%b",
                 i, v[i].op, alu_out, carry, zero, parity,
                 v[i].r, v[i].c, v[i].z, v[i].p);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[6];
    v = '{
      '{4'h4, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1},
      '{4'h5, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b1},
      '{4'h6, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b1},
      '{4'h7, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b1},
      '{4'hF, 16'hAAAA, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0},
      '{4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({alu_out, carry, zero, parity} !==
          {v[i].r, v[i].c, v[i].z, v[i].p}) begin
        failures++;
        $display("FAIL logic[%0d] op=%h: got %h c%b z%b p%b want %h c%b z%b p%b",
                 i, v[i].op, alu_out, carry, zero, parity,
                 v[i].r, v[i].c, v[i].z, v[i].p);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[10];
    v = '{
      '{4'h8, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0},
      '{4'hA, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0},
      '{4'hC, 16'h0001, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0},
      '{4'h9, 16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0},
      '{4'hB, 16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0},
      '{4'h8, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0, 1'b1},
      '{4'hC, 16'h0001, 16'hFFF0, 16'h0001, 1'b0, 1'b0, 1'b0},
      '{4'hA, 16'h8008, 16'h0004, 16'hF800, 1'b1, 1'b0, 1'b0},
      '{4'h9, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0},
      '{4'hB, 16'h0003, 16'h000F, 16'h8001, 1'b1, 1'b0, 1'b1}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({alu_out, carry, zero, parity} !==
          {v[i].r, v[i].c, v[i].z, v[i].p}) begin
        failures++;
        $display("FAIL shift[%0d] op=%h: got %h c%b z%b p%b want %h c%b z%b p%b",
                 i, v[i].op, alu_out, carry, zero, parity,
                 v[i].r, v[i].c, v[i].z, v[i].p);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    v = '{
      '{4'h1, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b0, 1'b0},
      '{4'h2, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1},
      '{4'h0, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b1},
      '{4'h6, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b1}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({alu_out, carry, zero, parity} !==
          {v[i].r, v[i].c, v[i].z, v[i].p}) begin
        failures++;
        $display("FAIL b2b[%0d] op=%h: got %h c%b z%b p%b want %h c%b z%b p%b",
                 i, v[i].op, alu_out, carry, zero, parity,
                 v[i].r, v[i].c, v[i].z, v[i].p);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(4'h1, 16'h0001, 16'h0001);
    checks++;
    if (alu_out !== 16'h0002) begin
      failures++;
      $display("FAIL pre_reset_add: got %h want 0002", alu_out);
    end
    @(negedge clk);
    rst      = 1'b1;
    opcode   = 4'h1;
    Rx_value = 16'h0005;
    Ry_value = 16'h0003;
    @(posedge clk);
    #1;
    checks++;
    if ({alu_out, carry, zero, parity} !== {16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL mid_reset: got %h c%b z%b p%b want 0000 0 0 0",
               alu_out, carry, zero, parity);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({alu_out, carry, zero, parity} !== {16'h0008, 3'b000}) begin
      failures++;
      $display("FAIL post_reset_add: got %h c%b z%b p%b want 0008 0 0 0",
               alu_out, carry, zero, parity);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    opcode   = 4'h0;
    Rx_value = 16'h0000;
    Ry_value = 16'h0000;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
